// File: rtl/m_dram_arbiter_pkg.sv
// Shared types and constants for the DRAM port arbiter: FSM encoding,
// requester ids, bus widths and the error read-data pattern.
package m_dram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int N_RQ   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef logic [1:0] rq_id_t;

  localparam rq_id_t RQ_INIT = 2'd0;
  localparam rq_id_t RQ_PTW  = 2'd1;
  localparam rq_id_t RQ_CORE = 2'd2;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  // Completion strobe for a granted requester; an unknown id yields no ack.
  function automatic logic [N_RQ-1:0] id_to_onehot(input rq_id_t id);
    case (id)
      RQ_INIT: id_to_onehot = 3'b001;
      RQ_PTW:  id_to_onehot = 3'b010;
      RQ_CORE: id_to_onehot = 3'b100;
      default: id_to_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/m_dram_arbiter_if.sv
// Requester, DRAM command and status signals of the arbiter, bundled.
// master = arbiter side, slave = requesters/DRAM side.
interface m_dram_arbiter_if;
  import m_dram_arbiter_pkg::*;

  logic                     w_init_done;
  logic [N_RQ-1:0]          w_rq_req;
  logic [N_RQ*ADDR_W-1:0]   w_rq_addr;
  logic [N_RQ-1:0]          w_rq_we;
  logic [N_RQ*DATA_W-1:0]   w_rq_wdata;
  logic [N_RQ-1:0]          w_rq_ack;
  logic [DATA_W-1:0]        w_rq_rdata;
  logic                     w_mem_valid;
  logic                     w_mem_ready;
  logic [ADDR_W-1:0]        w_mem_addr;
  logic                     w_mem_we;
  logic [DATA_W-1:0]        w_mem_wdata;
  logic                     w_mem_done;
  logic [DATA_W-1:0]        w_mem_rdata;
  logic                     w_busy;
  logic                     w_err;
  logic [1:0]               w_err_id;

  modport master (
    input  w_init_done, w_rq_req, w_rq_addr, w_rq_we, w_rq_wdata,
           w_mem_ready, w_mem_done, w_mem_rdata,
    output w_rq_ack, w_rq_rdata, w_mem_valid, w_mem_addr, w_mem_we,
           w_mem_wdata, w_busy, w_err, w_err_id
  );

  modport slave (
    output w_init_done, w_rq_req, w_rq_addr, w_rq_we, w_rq_wdata,
           w_mem_ready, w_mem_done, w_mem_rdata,
    input  w_rq_ack, w_rq_rdata, w_mem_valid, w_mem_addr, w_mem_we,
           w_mem_wdata, w_busy, w_err, w_err_id
  );

endinterface

// File: rtl/m_dram_arbiter_rrsel.sv
// Two-way round-robin picker between the page-table walker (req[0]) and
// the core (req[1]); winner=1 selects the core.
module m_dram_arbiter_rrsel (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       winner
);

  // On a tie, the side not granted last wins; last=1 means the core went last.
  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/m_dram_arbiter.sv
// Single-outstanding DRAM port arbiter: loader-only until init completes, then
// round-robin between walker and core, with a watchdog forcing error completion.
module m_dram_arbiter
  import m_dram_arbiter_pkg::*;
#(
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic             CLK,
  input  logic             RST_X,
  m_dram_arbiter_if.master bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  rq_id_t            id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  rq_id_t            err_id_q, err_id_d;
  logic              rr_last_q, rr_last_d;

  logic              rr_gnt_s;
  logic              rr_win_s;
  logic              grant_s;
  rq_id_t            win_id_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic              sel_we_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              done_s;
  logic              timeout_s;

  m_dram_arbiter_rrsel u_rrsel (
    .req       (bus.w_rq_req[2:1]),
    .last      (rr_last_q),
    .gnt_valid (rr_gnt_s),
    .winner    (rr_win_s)
  );

  // Eligibility gating by init phase and winner id.
  always_comb begin
    if (bus.w_init_done) begin
      grant_s  = rr_gnt_s;
      win_id_s = rr_win_s ? RQ_CORE : RQ_PTW;
    end else begin
      grant_s  = bus.w_rq_req[0];
      win_id_s = RQ_INIT;
    end
  end

  // Winner's command fields out of the packed requester buses.
  always_comb begin
    case (win_id_s)
      RQ_PTW: begin
        sel_addr_s  = bus.w_rq_addr[ADDR_W +: ADDR_W];
        sel_we_s    = bus.w_rq_we[1];
        sel_wdata_s = bus.w_rq_wdata[DATA_W +: DATA_W];
      end
      RQ_CORE: begin
        sel_addr_s  = bus.w_rq_addr[2*ADDR_W +: ADDR_W];
        sel_we_s    = bus.w_rq_we[2];
        sel_wdata_s = bus.w_rq_wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_addr_s  = bus.w_rq_addr[ADDR_W-1:0];
        sel_we_s    = bus.w_rq_we[0];
        sel_wdata_s = bus.w_rq_wdata[DATA_W-1:0];
      end
    endcase
  end

  // Completion (done only counts once the command was accepted) and watchdog expiry.
  always_comb begin
    case (state_q)
      S_ISSUE: done_s = bus.w_mem_ready && bus.w_mem_done;
      S_WAIT:  done_s = bus.w_mem_done;
      default: done_s = 1'b0;
    endcase
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      timeout_s = (cnt_q == CNT_LAST) && !done_s;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) state_d = S_ISSUE;
        else         state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (done_s || timeout_s)   state_d = S_RESP;
        else if (bus.w_mem_ready)  state_d = S_WAIT;
        else                       state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (done_s || timeout_s) state_d = S_RESP;
        else                     state_d = S_WAIT;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, watchdog count, read-data capture, error and RR bookkeeping.
  always_comb begin
    id_d      = id_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    err_id_d  = err_id_q;
    rr_last_d = rr_last_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          id_d    = win_id_s;
          addr_d  = sel_addr_s;
          we_d    = sel_we_s;
          wdata_d = sel_wdata_s;
          cnt_d   = {CNT_W{1'b0}};
          if (bus.w_init_done) rr_last_d = rr_win_s;
          else                 rr_last_d = rr_last_q;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_ISSUE, S_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (done_s) begin
          rdata_d = bus.w_mem_rdata;
        end else if (timeout_s) begin
          rdata_d  = ERR_DATA;
          err_d    = 1'b1;
          err_id_d = id_q;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // State and datapath registers; RR pointer resets so the walker wins the first tie.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q   <= S_IDLE;
      id_q      <= RQ_INIT;
      addr_q    <= {ADDR_W{1'b0}};
      we_q      <= 1'b0;
      wdata_q   <= {DATA_W{1'b0}};
      rdata_q   <= {DATA_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      err_q     <= 1'b0;
      err_id_q  <= RQ_INIT;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.w_mem_valid = (state_q == S_ISSUE);
    bus.w_busy      = (state_q != S_IDLE);
    if (state_q == S_RESP) bus.w_rq_ack = id_to_onehot(id_q);
    else                   bus.w_rq_ack = 3'b000;
    bus.w_rq_rdata  = rdata_q;
    bus.w_mem_addr  = addr_q;
    bus.w_mem_we    = we_q;
    bus.w_mem_wdata = wdata_q;
    bus.w_err       = err_q;
    bus.w_err_id    = err_id_q;
  end

endmodule
